// File: rtl/fetch_unit.sv
// fetch_unit: halfword instruction fetch with a DEPTH-entry buffer and branch redirect/discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, STALL, DISCARD} state_t;
  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d, addr_q, addr_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [47:0]     fifo_q [DEPTH];
  logic            branch, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign imem_req    = state_q == RUN || state_q == DISCARD;
  assign imem_addr   = addr_q;
  assign instr_valid = cnt_q != '0;
  assign {instruction, instr_pc} = instr_valid ? fifo_q[rptr_q] : 48'h0;

  always_comb begin
    branch  = branch_valid && state_q != IDLE;
    push    = state_q == RUN && imem_ack && !branch;
    pop     = instr_valid && instr_ready && !branch;
    cnt_d   = branch ? '0 : cnt_q + CW'(push) - CW'(pop);
    wptr_d  = branch ? '0 : push ? nxt(wptr_q) : wptr_q;
    rptr_d  = branch ? '0 : pop ? nxt(rptr_q) : rptr_q;
    pc_d    = branch ? {branch_target[31:1], 1'b0} : push ? pc_q + 32'd2 : pc_q;
    state_d = state_q == IDLE  ? RUN :
              branch           ? (imem_req && !imem_ack ? DISCARD : RUN) :
              state_q == RUN   ? (push && cnt_d == CW'(DEPTH) ? STALL : RUN) :
              state_q == STALL ? (cnt_d < CW'(DEPTH) ? RUN : STALL) :
              (imem_ack ? RUN : DISCARD);
    // While discarding, the memory still sees the stale address; the target waits in pc.
    addr_d  = state_d == DISCARD ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:1], 1'b0};
      addr_q  <= {RESET_PC[31:1], 1'b0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {imem_rdata, pc_q};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors; expected {instruction, pc} pairs queued by the driver, checked by a monitor.
module tb_fetch_unit;
  logic        clk, rst, imem_req, imem_ack, branch_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, branch_target, instr_pc;
  logic [15:0] imem_rdata, instruction;
  logic [47:0] exp_q [$];
  int          n_vec = 0, n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_valid(branch_valid),
    .branch_target(branch_target), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic ack, input logic [15:0] rd, input logic rdy, input logic br, input logic [31:0] tgt);
    imem_ack = ack; imem_rdata = rd; instr_ready = rdy; branch_valid = br; branch_target = tgt;
    if (br) exp_q.delete();
  endtask

  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready && !branch_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL head: got %h%h want nothing (queue empty)", instruction, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if ({instruction, instr_pc} !== e) begin
            n_bad++;
            $display("FAIL head: got %h/%h want %h/%h", instruction, instr_pc, e[47:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    drv(0, 16'h0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instr_pc, 0);
    drv(1, 16'h1C08, 1, 0, 32'h0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 32'(2 * i));
      chk("seq_valid", instr_valid, 32'(i != 0));
      exp_q.push_back({16'h1C08, 32'(2 * i)});
    end
    @(negedge clk);
    chk("pre_br_addr", imem_addr, 32'h6);
    drv(0, 16'h0, 1, 0, 32'h0);
    @(negedge clk);
    chk("br_addr", imem_addr, 32'h6);
    chk("br_valid", instr_valid, 0);
    drv(0, 16'h0, 1, 1, 32'h101);
    @(negedge clk);
    chk("disc_req", imem_req, 1);
    chk("disc_addr", imem_addr, 32'h6);
    drv(0, 16'h0, 1, 1, 32'h301);
    @(negedge clk);
    chk("disc2_addr", imem_addr, 32'h6);
    drv(1, 16'hDEAD, 1, 0, 32'h0);
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h300);
    chk("drop_valid", instr_valid, 0);
    drv(1, 16'hA000, 0, 0, 32'h0);
    exp_q.push_back({16'hA000, 32'h300});
    @(negedge clk);
    chk("fill_addr", imem_addr, 32'h302);
    chk("fill_valid", instr_valid, 1);
    drv(1, 16'hA001, 0, 0, 32'h0);
    exp_q.push_back({16'hA001, 32'h302});
    @(negedge clk);
    chk("full_req", imem_req, 0);
    chk("full_pc", instr_pc, 32'h300);
    drv(1, 16'h5555, 1, 1, 32'h400);
    @(negedge clk);
    chk("flush_valid", instr_valid, 0);
    chk("flush_req", imem_req, 1);
    chk("flush_addr", imem_addr, 32'h400);
    drv(1, 16'hB000, 1, 0, 32'h0);
    exp_q.push_back({16'hB000, 32'h400});
    @(negedge clk);
    chk("b_valid", instr_valid, 1);
    drv(1, 16'hB002, 1, 1, 32'h500);
    @(negedge clk);
    chk("bpp_valid", instr_valid, 0);
    chk("bpp_addr", imem_addr, 32'h500);
    drv(1, 16'hC000, 0, 0, 32'h0);
    exp_q.push_back({16'hC000, 32'h500});
    @(negedge clk);
    chk("c_valid", instr_valid, 1);
    chk("c_addr", imem_addr, 32'h502);
    drv(0, 16'h0, 0, 0, 32'h0);
    #3 rst = 1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instruction, 0);
    chk("arst_pc", instr_pc, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    drv(1, 16'h2222, 0, 0, 32'h0);
    @(negedge clk);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", imem_req, 1);
    exp_q.push_back({16'h2222, 32'h0});
    @(negedge clk);
    chk("st_addr", imem_addr, 32'h2);
    drv(1, 16'h3333, 0, 0, 32'h0);
    exp_q.push_back({16'h3333, 32'h2});
    @(negedge clk);
    chk("stall_req", imem_req, 0);
    chk("stall_pc", instr_pc, 32'h0);
    @(negedge clk);
    chk("stall_hold", imem_req, 0);
    drv(1, 16'h3333, 1, 0, 32'h0);
    @(negedge clk);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h4);
    chk("resume_pc", instr_pc, 32'h2);
    drv(0, 16'h0, 0, 0, 32'h0);
    @(negedge clk);
    drv(0, 16'h0, 1, 0, 32'h0);
    @(negedge clk);
    chk("drain_valid", instr_valid, 0);
    drv(1, 16'hEEEE, 1, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("top_addr", imem_addr, 32'hFFFF_FFFE);
    chk("top_valid", instr_valid, 0);
    drv(1, 16'h7777, 1, 0, 32'h0);
    exp_q.push_back({16'h7777, 32'hFFFF_FFFE});
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_valid", instr_valid, 1);
    drv(0, 16'h0, 1, 0, 32'h0);
    @(negedge clk);
    chk("end_valid", instr_valid, 0);
    chk("end_queue", exp_q.size(), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset; bit 0 SHALL be treated as 0.
REQ-002 Parameter DEPTH, 2, instruction buffer entries; legal range 2..8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  halfword address of the pending request.
REQ-007 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 imem_rdata  input  16  instruction halfword; valid only when imem_ack=1.
REQ-009 branch_valid  input  1  redirect request from execute.
REQ-010 branch_target  input  32  redirect address; bit 0 ignored.
REQ-011 instr_valid  output  1  buffer head holds an instruction for decode.
REQ-012 instruction  output  16  buffer head instruction, driving the decode stage.
REQ-013 instr_pc  output  32  address of the buffer head instruction.
REQ-014 instr_ready  input  1  decode consumes the head this cycle.

Function
REQ-015 The block SHALL hold a PC, a DEPTH-entry FIFO of {instruction, pc}, an occupancy count 0..DEPTH, and a state machine with states IDLE, RUN, STALL and DISCARD.
REQ-016 imem_req SHALL be 1 only in RUN and DISCARD; imem_addr SHALL equal the PC and SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-017 IDLE -> RUN SHALL occur on the first clock edge after rst deasserts.
REQ-018 In RUN with imem_ack=1 and no branch, the block SHALL push {imem_rdata, PC}, set PC to PC+2 (mod 2^32), and stay in RUN if post-update occupancy < DEPTH, otherwise go to STALL.
REQ-019 STALL -> RUN SHALL occur on the edge where occupancy drops below DEPTH.
REQ-020 Pop SHALL occur when instr_valid=1 and instr_ready=1; instr_valid SHALL equal (occupancy != 0); instruction and instr_pc SHALL be the FIFO head.
REQ-021 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 Sustained ack and ready SHALL deliver one instruction per cycle, with a push-to-instr_valid latency of 1 cycle.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-024 On branch_valid=1 in any non-IDLE state, the block SHALL flush the FIFO (occupancy 0, no pop counted), set PC to {branch_target[31:1],1'b0}, and discard the same-cycle imem_rdata.
REQ-025 The next state after a branch SHALL be DISCARD if imem_req=1 and imem_ack=0 in the branch cycle, otherwise RUN.
REQ-026 In DISCARD, imem_addr SHALL keep the stale pre-branch address and the PC SHALL hold the target separately; on imem_ack the data SHALL be dropped and the state SHALL go to RUN with imem_addr = target.
REQ-027 A branch in DISCARD SHALL update the held target and remain in DISCARD.
REQ-028 Branch, push and pop in the same cycle SHALL resolve so that the branch wins: no push and occupancy 0.
REQ-029 instr_valid SHALL be 0 in the cycle after any branch.
REQ-030 The FIFO SHALL never overflow, and a pop SHALL never occur when empty.

Reset
REQ-031 While rst=1: state IDLE, PC=RESET_PC, occupancy 0, pointers 0, imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
REQ-032 rst asserted mid-request SHALL drop the request immediately, and any later imem_ack SHALL be ignored until RUN.

Verification
REQ-033 Reset release, ack held 1, ready 1, rdata=16'h1C08 -> imem_addr sequence 0,2,4,...; instruction 1C08 with instr_pc 0 one cycle after the first ack.
REQ-034 ready=0, ack=1, DEPTH=2 -> two pushes, imem_req=0 (STALL), instr_pc=0; ready=1 for one cycle -> returns to RUN, addr=4.
REQ-035 ack=0 at addr 6, branch_valid with target 32'h101 -> DISCARD with addr 6 held; ack -> data dropped, next imem_addr=32'h100.
REQ-036 FIFO full plus branch, push and pop in the same cycle -> occupancy 0, instr_valid=0 next cycle, imem_addr=target.
REQ-037 rst pulsed while imem_req=1 and the FIFO holds 2 entries -> all outputs reach reset values asynchronously, and fetch restarts at RESET_PC.
REQ-038 PC at 32'hFFFF_FFFE with ack -> next imem_addr=0, with no error.
